caliptra_fpga_event_monitor: RTL

//  Parametrised N-channel breakpoint/event monitor in the aclk_gated domain of the FPGA sync wrapper.

---
 rtl/caliptra_fpga_event_pkg.sv | 37 +++
 rtl/caliptra_fpga_event_fifo.sv | 63 ++++++
 rtl/caliptra_fpga_event_monitor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/caliptra_fpga_event_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : caliptra_fpga_event_pkg
// Description : Shared types for the sync-wrapper event monitor: channel
//               watch modes and the event FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package caliptra_fpga_event_pkg;

    // Per-channel watch mode, encoded as driven on ch_mode_i
    typedef enum logic [1:0] {
        EV_LEVEL  = 2'b00,
        EV_CHANGE = 2'b01,
        EV_RISE   = 2'b10,
        EV_FALL   = 2'b11
    } ev_mode_e;

    // Default entry geometry, matching the monitor's default parameters
    localparam int EV_NUM_CH = 4;
    localparam int EV_CH_W   = 64;
    localparam int EV_TS_W   = 32;

    // Entry layout, MSB first: timestamp, hit vector, data
    typedef struct packed {
        logic [EV_TS_W-1:0]   ts;
        logic [EV_NUM_CH-1:0] hits;
        logic [EV_CH_W-1:0]   data;
    } ev_entry_t;

    // Flat width of an entry for an arbitrary monitor configuration
    function automatic int ev_entry_width(input int ts_w, input int num_ch, input int ch_w);
        return ts_w + num_ch + ch_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/caliptra_fpga_event_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : caliptra_fpga_event_fifo
// Description : Show-ahead synchronous FIFO with occupancy output. The head
//               entry is presented from storage registers whenever not empty.
//               Push while full is accepted only if a pop frees a slot.
// Revision    : 1.0 - initial release
// ============================================================================
module caliptra_fpga_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     aclk_gated,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // DEPTH is a power of two and count never exceeds it, so the MSB alone means full
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    // Entry storage; contents are don't-care until written
    always_ff @(posedge aclk_gated) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge aclk_gated or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/caliptra_fpga_event_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : caliptra_fpga_event_monitor
// Description : N-channel breakpoint/event monitor. Each channel compares a
//               masked watched value against its previous value under a
//               per-channel mode, drives a zero-latency breakpoint, keeps a
//               sticky hit and a saturating count, and logs timestamped hits
//               into a show-ahead event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module caliptra_fpga_event_monitor
    import caliptra_fpga_event_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_W       = 32,
    parameter int CNT_W      = 16
) (
    input  logic                          aclk_gated,
    input  logic                          rstn,
    input  logic [NUM_CH*CH_W-1:0]        ch_data_i,
    input  logic [NUM_CH*CH_W-1:0]        ch_mask_i,
    input  logic [NUM_CH*2-1:0]           ch_mode_i,
    input  logic [NUM_CH-1:0]             ch_en_i,
    input  logic                          clr_i,
    output logic                          bkpt_o,
    output logic [NUM_CH-1:0]             hit_o,
    output logic [NUM_CH*CNT_W-1:0]       hit_cnt_o,
    output logic                          ev_valid_o,
    input  logic                          ev_pop_i,
    output logic [TS_W-1:0]               ev_ts_o,
    output logic [NUM_CH-1:0]             ev_hits_o,
    output logic [CH_W-1:0]               ev_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   ev_level_o,
    output logic                          ev_overflow_o,
    output logic [CNT_W-1:0]              ev_drop_cnt_o
);

    localparam int ENTRY_W = ev_entry_width(TS_W, NUM_CH, CH_W);

    logic [CH_W-1:0]    ch_data [NUM_CH];
    logic [NUM_CH-1:0]  hit_now;
    logic               prev_valid;
    logic [TS_W-1:0]    ts;
    logic [CH_W-1:0]    sel_data;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic               drop;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CH_W-1:0]  prev;
        logic [CH_W-1:0]  m;
        logic [CH_W-1:0]  pm;
        logic             cond;
        logic             hit_q;
        logic [CNT_W-1:0] cnt;

        assign ch_data[i] = ch_data_i[i*CH_W +: CH_W];
        assign m          = ch_data[i] & ch_mask_i[i*CH_W +: CH_W];
        assign pm         = prev & ch_mask_i[i*CH_W +: CH_W];

        // Mode condition; edge modes need a valid previous sample
        always_comb begin
            cond = 1'b0;
            case (ev_mode_e'(ch_mode_i[2*i +: 2]))
                EV_LEVEL:  cond = |m;
                EV_CHANGE: cond = prev_valid & (|(m ^ pm));
                EV_RISE:   cond = prev_valid & (|(m & ~pm));
                EV_FALL:   cond = prev_valid & (|(~m & pm));
                default:   cond = 1'b0;
            endcase
        end

        assign hit_now[i] = ch_en_i[i] & cond;

        // Previous sample, sticky hit and saturating count; a hit coincident with clear survives it
        always_ff @(posedge aclk_gated or negedge rstn) begin
            if (!rstn) begin
                prev  <= '0;
                hit_q <= 1'b0;
                cnt   <= '0;
            end else begin
                prev <= ch_data[i];
                if (clr_i) begin
                    hit_q <= hit_now[i];
                    cnt   <= hit_now[i] ? CNT_W'(1) : '0;
                end else if (hit_now[i]) begin
                    hit_q <= 1'b1;
                    if (cnt != '1) cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign hit_o[i]                     = hit_q;
        assign hit_cnt_o[i*CNT_W +: CNT_W]  = cnt;
    end

    assign bkpt_o = |hit_now;

    // Data of the lowest-index channel hitting this cycle
    always_comb begin
        sel_data = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit_now[i]) sel_data = ch_data[i];
        end
    end

    // Free-running timestamp and first-edge qualifier for edge modes
    always_ff @(posedge aclk_gated or negedge rstn) begin
        if (!rstn) begin
            prev_valid <= 1'b0;
            ts         <= '0;
        end else begin
            prev_valid <= 1'b1;
            ts         <= ts + TS_W'(1);
        end
    end

    assign push       = |hit_now;
    assign push_entry = {ts, hit_now, sel_data};
    assign drop       = push & fifo_full & ~ev_pop_i;

    caliptra_fpga_event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk_gated (aclk_gated),
        .rstn       (rstn),
        .push       (push),
        .pop        (ev_pop_i),
        .wdata      (push_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .rdata      (head_entry),
        .level      (ev_level_o)
    );

    assign ev_valid_o = ~fifo_empty;
    assign ev_ts_o    = head_entry[ENTRY_W-1 -: TS_W];
    assign ev_hits_o  = head_entry[CH_W +: NUM_CH];
    assign ev_data_o  = head_entry[CH_W-1:0];

    // Overflow flag and saturating drop count; a drop coincident with clear survives it
    always_ff @(posedge aclk_gated or negedge rstn) begin
        if (!rstn) begin
            ev_overflow_o <= 1'b0;
            ev_drop_cnt_o <= '0;
        end else if (clr_i) begin
            ev_overflow_o <= drop;
            ev_drop_cnt_o <= drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            ev_overflow_o <= 1'b1;
            if (ev_drop_cnt_o != '1) ev_drop_cnt_o <= ev_drop_cnt_o + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
